fp_mul_sequencer: RTL

- Front-end stage that feeds the multi-cycle single-precision multiplier and collects its results.
- Buffers operand pairs in a small FIFO and sequences the multiplier's level-sampled `ready` / one-cycle `done` protocol.
- Presents each product on a valid/ready output register.
- Watchdog flags a multiplier that never answers.

---
 rtl/fp_mul_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fp_mul_sequencer.sv
// fp_mul_sequencer
// Front end for the multi-cycle single-precision multiplier. Operand pairs are
// buffered in a small FIFO, handed to the multiplier one at a time using its
// level-sampled ready / one-cycle done protocol, and each product is presented
// on a valid/ready output register. A watchdog substitutes a quiet NaN and
// raises a sticky error if the multiplier never answers.
//
// Optional feature macro: FPMUL_SEQ_CNT_EN (adds op_count and busy outputs).
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    operand pair handshake (in_ready = FIFO not full)
//   in_op1, in_op2       IEEE754 operands A and B
//   mul_ready            one-cycle start pulse to the multiplier
//   mul_op1, mul_op2     operands to the multiplier, stable around the pulse
//   mul_res, mul_done    multiplier result and its one-cycle completion pulse
//   out_valid/out_ready  result handshake
//   out_data             product (or 7FC00000 after a watchdog timeout)
//   err                  sticky watchdog error
//   op_count, busy       (FPMUL_SEQ_CNT_EN only) handoff count, FSM active
module fp_mul_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic        mul_ready,
  output logic [31:0] mul_op1,
  output logic [31:0] mul_op2,
  input  logic [31:0] mul_res,
  input  logic        mul_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        err
`ifdef FPMUL_SEQ_CNT_EN
  ,
  output logic [15:0] op_count,
  output logic        busy
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ISSUE, S_WAIT} state_t;

  state_t        state, state_next;
  logic [31:0]   fifo_a [DEPTH];
  logic [31:0]   fifo_b [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  logic [CW-1:0] wd_cnt;
  logic          timeout_hit;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty       = (wr_ptr == rd_ptr);
  assign in_ready    = !full;
  assign push        = in_valid && !full;
  assign timeout_hit = (wd_cnt == CW'(TIMEOUT - 1));

  // The head is popped on the edge that enters S_SETUP, so the operand
  // registers are already valid throughout S_SETUP and thus stable for one
  // full cycle before the ready pulse in S_ISSUE.
  assign pop = (state == S_IDLE) && (state_next == S_SETUP);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!empty && !out_valid) state_next = S_SETUP;
      S_SETUP: state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (mul_done || timeout_hit) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_a[i] <= '0;
        fifo_b[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_a[wr_ptr[AW-1:0]] <= in_op1;
        fifo_b[wr_ptr[AW-1:0]] <= in_op2;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // mul_ready is decoded from the next state so it is a clean register output.
  // A done pulse seen outside S_WAIT is ignored, and done wins over a timeout
  // landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mul_ready <= 1'b0;
      mul_op1   <= '0;
      mul_op2   <= '0;
      wd_cnt    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      mul_ready <= (state_next == S_ISSUE);
      if (pop) begin
        mul_op1 <= fifo_a[rd_ptr[AW-1:0]];
        mul_op2 <= fifo_b[rd_ptr[AW-1:0]];
      end
      if (state == S_ISSUE)      wd_cnt <= '0;
      else if (state == S_WAIT)  wd_cnt <= wd_cnt + 1'b1;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (state == S_WAIT) begin
        if (mul_done) begin
          out_data  <= mul_res;
          out_valid <= 1'b1;
        end else if (timeout_hit) begin
          err       <= 1'b1;
          out_data  <= QNAN;
          out_valid <= 1'b1;
        end
      end
    end
  end

`ifdef FPMUL_SEQ_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         op_count <= '0;
    else if (out_valid && out_ready) op_count <= op_count + 16'd1;
  end

  assign busy = (state != S_IDLE);
`endif

endmodule
